// File: rtl/spike_noc_pkg.sv
// Shared spike NoC definitions: default widths, spike packet field layout and the
// round-robin pointer type used by the injection arbiter.
package spike_noc_pkg;

   localparam int unsigned PKT_WIDTH_DEFAULT     = 32;
   localparam int unsigned REQ_IDX_WIDTH_DEFAULT = 2;

   // Spike packet layout: destination router coordinates above the neuron address.
   localparam int unsigned PKT_NEURON_LSB   = 0;
   localparam int unsigned PKT_NEURON_WIDTH = 16;
   localparam int unsigned PKT_DEST_X_LSB   = 16;
   localparam int unsigned PKT_DEST_X_WIDTH = 8;
   localparam int unsigned PKT_DEST_Y_LSB   = 24;
   localparam int unsigned PKT_DEST_Y_WIDTH = 8;

   typedef logic [REQ_IDX_WIDTH_DEFAULT-1:0] rr_ptr_t;

endpackage

// File: rtl/spike_inject_arbiter_if.sv
// Source-side and router-side handshake bundle of the spike injection arbiter.
interface spike_inject_arbiter_if #(
   parameter int NUM_REQ       = 4,
   parameter int REQ_IDX_WIDTH = 2,
   parameter int PKT_WIDTH     = 32
);
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ*PKT_WIDTH-1:0] req_packet;
   logic [NUM_REQ-1:0]           req_ready;
   logic                         local_full;
   logic [PKT_WIDTH-1:0]         local_in;
   logic                         write_en_local;
   logic [REQ_IDX_WIDTH-1:0]     grant_id;

   modport master (
      output req_valid, req_packet, local_full,
      input  req_ready, local_in, write_en_local, grant_id
   );

   modport slave (
      input  req_valid, req_packet, local_full,
      output req_ready, local_in, write_en_local, grant_id
   );
endinterface

// File: rtl/spike_inject_arbiter_rr_arbiter_comb.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo NUM_REQ.
module rr_arbiter_comb #(
   parameter int NUM_REQ       = 4,
   parameter int REQ_IDX_WIDTH = 2
) (
   input  logic [NUM_REQ-1:0]       req,
   input  logic [REQ_IDX_WIDTH-1:0] ptr,
   output logic [REQ_IDX_WIDTH-1:0] winner,
   output logic                     any
);
   import spike_noc_pkg::*;

   int   idx;
   logic found;

   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(ptr) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            winner = idx[REQ_IDX_WIDTH-1:0];
            found  = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/spike_inject_arbiter.sv
// Shares the router local injection port among NUM_REQ sources, one holding buffer each,
// with round-robin arbitration, router backpressure, a step fence and a sent counter.
module spike_inject_arbiter
   import spike_noc_pkg::*;
#(
   parameter int NUM_REQ       = 4,
   parameter int REQ_IDX_WIDTH = int'(REQ_IDX_WIDTH_DEFAULT),
   parameter int PKT_WIDTH     = int'(PKT_WIDTH_DEFAULT),
   parameter int CNT_WIDTH     = 16
) (
   input  logic                  rt_clk,
   input  logic                  rt_reset,
   spike_inject_arbiter_if.slave bus,
   input  logic                  step_fence,
   output logic                  drained,
   output logic [CNT_WIDTH-1:0]  sent_count,
   input  logic                  count_clear
);

   logic [NUM_REQ-1:0]       occ_q;
   logic [PKT_WIDTH-1:0]     buf_q [NUM_REQ];
   logic [REQ_IDX_WIDTH-1:0] ptr_q;
   logic [CNT_WIDTH-1:0]     cnt_q;

   logic [REQ_IDX_WIDTH-1:0] winner;
   logic                     any;
   logic                     wr_en;
   logic [NUM_REQ-1:0]       wr_grant;
   logic [NUM_REQ-1:0]       ready;

   rr_arbiter_comb #(
      .NUM_REQ       (NUM_REQ),
      .REQ_IDX_WIDTH (REQ_IDX_WIDTH)
   ) u_rr (
      .req    (occ_q),
      .ptr    (ptr_q),
      .winner (winner),
      .any    (any)
   );

   always_comb begin
      wr_en    = any && !bus.local_full && !rt_reset;
      wr_grant = wr_en ? (NUM_REQ'(1) << winner) : '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // A granted buffer frees at this edge, so it can take a new packet in the same cycle.
         ready[i] = !rt_reset && !step_fence && (!occ_q[i] || wr_grant[i]);
      end
   end

   assign bus.req_ready      = ready;
   assign bus.write_en_local = wr_en;
   assign bus.local_in       = rt_reset ? '0 : buf_q[winner];
   assign bus.grant_id       = rt_reset ? '0 : winner;
   assign drained            = step_fence && !(|occ_q);
   assign sent_count         = cnt_q;

   always_ff @(posedge rt_clk) begin
      if (rt_reset) begin
         occ_q <= '0;
         ptr_q <= REQ_IDX_WIDTH'(NUM_REQ - 1);
         cnt_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && ready[i]) begin
               buf_q[i] <= bus.req_packet[i*PKT_WIDTH +: PKT_WIDTH];
               occ_q[i] <= 1'b1;
            end else if (wr_grant[i]) begin
               occ_q[i] <= 1'b0;
            end
         end
         if (wr_en) begin
            ptr_q <= winner;
         end
         if (count_clear) begin
            cnt_q <= '0;
         end else if (wr_en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_spike_inject_arbiter.sv
// Directed bench for spike_inject_arbiter: reset, round robin, backpressure, streaming,
// step fence, counter saturation/clear and mid-operation reset.
module tb_spike_inject_arbiter;
   import spike_noc_pkg::*;

   localparam int NR = 4;
   localparam int IW = 2;
   localparam int PW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          fence = 1'b0;
   logic          clr = 1'b0;
   logic          drained;
   logic [CW-1:0] cnt;
   int            checks = 0;
   int            errors = 0;

   spike_inject_arbiter_if #(.NUM_REQ(NR), .REQ_IDX_WIDTH(IW), .PKT_WIDTH(PW)) bus ();

   spike_inject_arbiter #(
      .NUM_REQ       (NR),
      .REQ_IDX_WIDTH (IW),
      .PKT_WIDTH     (PW),
      .CNT_WIDTH     (CW)
   ) dut (
      .rt_clk      (clk),
      .rt_reset    (rst),
      .bus         (bus),
      .step_fence  (fence),
      .drained     (drained),
      .sent_count  (cnt),
      .count_clear (clr)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic exp_wr(input string tag, input logic w, input rr_ptr_t g, input logic [31:0] d);
      chk({tag, ".wen"}, 32'(bus.write_en_local), 32'(w));
      if (w) begin
         chk({tag, ".gid"}, 32'(bus.grant_id), 32'(g));
         chk({tag, ".data"}, bus.local_in, d);
      end
   endtask

   task automatic set_pkt(input int i, input logic [31:0] v);
      bus.req_packet[i*PW +: PW] = v;
   endtask

   function automatic logic [31:0] pk(input int i);
      return 32'hA000_0001 | (32'(i) << 24);
   endfunction

   initial begin
      bus.req_valid  = 4'b1111;
      bus.local_full = 1'b0;
      for (int i = 0; i < NR; i++) set_pkt(i, pk(i));

      // Reset held three cycles with every source valid.
      for (int r = 0; r < 3; r++) begin
         tick();
         chk("rst.ready", 32'(bus.req_ready), 32'h0);
         chk("rst.wen", 32'(bus.write_en_local), 32'h0);
         chk("rst.cnt", 32'(cnt), 32'h0);
      end
      chk("rst.local_in", bus.local_in, 32'h0);
      chk("rst.gid", 32'(bus.grant_id), 32'h0);

      tick();
      rst = 1'b0;
      #1;
      chk("rel.ready", 32'(bus.req_ready), 32'hF);
      chk("rel.wen", 32'(bus.write_en_local), 32'h0);

      // All sources continuously valid: grants rotate 0..3 twice.
      for (int k = 0; k < 8; k++) begin
         tick();
         exp_wr("rr", 1'b1, rr_ptr_t'(k % 4), pk(k % 4));
         chk("rr.ready", 32'(bus.req_ready), 32'(1) << (k % 4));
      end

      tick();
      bus.req_valid = 4'b0000;
      #1;
      chk("rr.cnt", 32'(cnt), 32'd8);
      exp_wr("drain0", 1'b1, 2'd0, pk(0));
      for (int k = 1; k < 4; k++) begin
         tick();
         exp_wr("drain", 1'b1, rr_ptr_t'(k), pk(k));
      end
      tick();
      exp_wr("drain.idle", 1'b0, 2'd0, 32'h0);

      // Backpressure with sources 1 and 3 buffered.
      tick();
      bus.req_valid  = 4'b1010;
      bus.local_full = 1'b1;
      set_pkt(1, 32'hB1);
      set_pkt(3, 32'hB3);
      #1;
      chk("bp.load_ready", 32'(bus.req_ready), 32'hF);
      for (int k = 0; k < 5; k++) begin
         tick();
         bus.req_valid = 4'b0000;
         #1;
         chk("bp.wen", 32'(bus.write_en_local), 32'h0);
         chk("bp.ready", 32'(bus.req_ready), 32'h5);
      end
      tick();
      bus.local_full = 1'b0;
      #1;
      exp_wr("bp.rel1", 1'b1, 2'd1, 32'hB1);
      tick();
      exp_wr("bp.rel3", 1'b1, 2'd3, 32'hB3);
      tick();
      exp_wr("bp.idle", 1'b0, 2'd0, 32'h0);

      // Single source streaming one packet per cycle; counter cleared first.
      for (int k = 0; k <= 10; k++) begin
         tick();
         bus.req_valid = (k < 10) ? 4'b0100 : 4'b0000;
         set_pkt(2, 32'h20 + 32'(k));
         clr = (k == 0);
         #1;
         if (k > 0) exp_wr("stream", 1'b1, 2'd2, 32'h20 + 32'(k - 1));
         if (k < 10) chk("stream.ready", 32'(bus.req_ready[2]), 32'h1);
      end
      tick();
      exp_wr("stream.idle", 1'b0, 2'd0, 32'h0);
      chk("stream.cnt", 32'(cnt), 32'd10);

      // Step fence with three buffers occupied.
      tick();
      bus.req_valid  = 4'b0111;
      bus.local_full = 1'b1;
      for (int i = 0; i < 3; i++) set_pkt(i, 32'hC0 + 32'(i));
      #1;
      tick();
      fence          = 1'b1;
      bus.local_full = 1'b0;
      bus.req_valid  = 4'b1111;
      #1;
      chk("fence.ready", 32'(bus.req_ready), 32'h0);
      chk("fence.drained0", 32'(drained), 32'h0);
      exp_wr("fence.w0", 1'b1, 2'd0, 32'hC0);
      tick();
      exp_wr("fence.w1", 1'b1, 2'd1, 32'hC1);
      tick();
      exp_wr("fence.w2", 1'b1, 2'd2, 32'hC2);
      chk("fence.drained_w2", 32'(drained), 32'h0);
      tick();
      exp_wr("fence.done", 1'b0, 2'd0, 32'h0);
      chk("fence.drained", 32'(drained), 32'h1);
      chk("fence.ready2", 32'(bus.req_ready), 32'h0);
      tick();
      fence         = 1'b0;
      bus.req_valid = 4'b1000;
      set_pkt(3, 32'hD3);
      #1;
      chk("unfence.ready", 32'(bus.req_ready), 32'hF);
      chk("unfence.drained", 32'(drained), 32'h0);
      tick();
      bus.req_valid = 4'b0000;
      #1;
      exp_wr("unfence.w", 1'b1, 2'd3, 32'hD3);
      tick();
      fence = 1'b1;
      #1;
      chk("fence.empty_drained", 32'(drained), 32'h1);
      exp_wr("fence.empty", 1'b0, 2'd0, 32'h0);
      fence = 1'b0;

      // Counter saturation: 20 writes into a 4-bit counter.
      for (int k = 0; k <= 20; k++) begin
         tick();
         bus.req_valid = (k < 20) ? 4'b0001 : 4'b0000;
         set_pkt(0, 32'(k));
         clr = (k == 0);
         #1;
         if (k > 0) exp_wr("sat", 1'b1, 2'd0, 32'(k - 1));
      end
      tick();
      chk("sat.cnt", 32'(cnt), 32'd15);

      // Clear coincident with a write wins.
      tick();
      bus.req_valid = 4'b0001;
      set_pkt(0, 32'h55);
      #1;
      tick();
      bus.req_valid = 4'b0000;
      clr = 1'b1;
      #1;
      exp_wr("clr.w", 1'b1, 2'd0, 32'h55);
      tick();
      clr = 1'b0;
      #1;
      chk("clr.cnt", 32'(cnt), 32'h0);

      // Mid-operation reset suppresses the pending write and discards the buffer.
      tick();
      bus.req_valid = 4'b0001;
      set_pkt(0, 32'h77);
      #1;
      tick();
      bus.req_valid = 4'b0000;
      rst = 1'b1;
      #1;
      chk("mrst.wen", 32'(bus.write_en_local), 32'h0);
      chk("mrst.local_in", bus.local_in, 32'h0);
      chk("mrst.ready", 32'(bus.req_ready), 32'h0);
      tick();
      rst = 1'b0;
      #1;
      chk("mrst.discard", 32'(bus.write_en_local), 32'h0);
      chk("mrst.cnt", 32'(cnt), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
